// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants and terminal-value helper for the modulo counter
package contador_pkg;

  localparam logic CONTA_CIMA    = 1'b1;
  localparam logic CONTA_BAIXO   = 1'b0;
  localparam logic MODO_CIRCULAR = 1'b0;
  localparam logic MODO_SATURA   = 1'b1;

  // Terminal count: MODULO-1 when counting up, 0 when counting down.
  function automatic int unsigned valor_terminal(input int unsigned modulo, input logic direcao);
    return (direcao == CONTA_CIMA) ? (modulo - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/contador_mod_ud_detector_terminal.sv
// rtl/contador_mod_ud_detector_terminal.sv - combinational terminal-count and RCO detector
module detector_terminal
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  input  logic             i_ent,
  output logic             o_terminal,
  output logic             o_rco
);

  localparam logic [WIDTH-1:0] TERM_CIMA  = WIDTH'(valor_terminal(MODULO, CONTA_CIMA));
  localparam logic [WIDTH-1:0] TERM_BAIXO = WIDTH'(valor_terminal(MODULO, CONTA_BAIXO));

  logic [WIDTH-1:0] w_alvo;

  assign w_alvo     = i_up ? TERM_CIMA : TERM_BAIXO;
  assign o_terminal = (i_q == w_alvo);
  assign o_rco      = i_ent & o_terminal;

endmodule

// File: rtl/contador_mod_ud.sv
// rtl/contador_mod_ud.sv - cascadable up/down modulo counter with load clamp, RCO and wrap pulse
module contador_mod_ud
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16,
  parameter int SATURA = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LD,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(valor_terminal(MODULO, CONTA_CIMA));
  localparam logic [WIDTH-1:0] UM   = WIDTH'(1);
  localparam bit               SAT  = (SATURA == int'(MODO_SATURA));

  if ((WIDTH < 2) || (WIDTH > 16)) begin : g_bad_width
    $error("contador_mod_ud: WIDTH=%0d outside 2..16", WIDTH);
  end
  if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
    $error("contador_mod_ud: MODULO=%0d outside 2..2^WIDTH", MODULO);
  end
  if ((SATURA != 0) && (SATURA != 1)) begin : g_bad_satura
    $error("contador_mod_ud: SATURA=%0d must be 0 or 1", SATURA);
  end

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic             w_terminal;
  logic             w_step;
  logic [WIDTH-1:0] w_d_clamp;

  assign w_step    = ENP & ENT;
  assign w_d_clamp = (D > MAXV) ? MAXV : D;

  detector_terminal #(
    .WIDTH  (WIDTH),
    .MODULO (MODULO)
  ) u_detector (
    .i_q        (r_q),
    .i_up       (UP),
    .i_ent      (ENT),
    .o_terminal (w_terminal),
    .o_rco      (RCO)
  );

  // OVF defaults low so it is a single-cycle pulse; only a wrap step raises it.
  always_ff @(posedge CLK) begin
    r_ovf <= 1'b0;
    if (CLR) begin
      r_q <= '0;
    end else if (!LD) begin
      r_q <= w_d_clamp;
    end else if (w_step) begin
      if (w_terminal) begin
        if (!SAT) begin
          r_q   <= UP ? '0 : MAXV;
          r_ovf <= 1'b1;
        end
      end else begin
        r_q <= UP ? (r_q + UM) : (r_q - UM);
      end
    end
  end

  assign Q   = r_q;
  assign OVF = r_ovf;

endmodule

// File: tb/tb_contador_mod_ud.sv
// tb/tb_contador_mod_ud.sv - directed self-checking bench for contador_mod_ud
module tb_contador_mod_ud;

  logic clk;
  int   n_tests;
  int   n_fail;

  logic       a_clr, a_ld, a_enp, a_ent, a_up;
  logic [3:0] a_d, a_q;
  logic       a_rco, a_ovf;

  logic       b_clr, b_ld, b_enp, b_ent, b_up;
  logic [3:0] b_d, b_q;
  logic       b_rco, b_ovf;

  logic       c_clr, c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_rco, lo_ovf, hi_rco, hi_ovf;

  contador_mod_ud #(.WIDTH(4), .MODULO(10), .SATURA(0)) dut_a (
    .CLK(clk), .CLR(a_clr), .LD(a_ld), .ENP(a_enp), .ENT(a_ent), .UP(a_up),
    .D(a_d), .Q(a_q), .RCO(a_rco), .OVF(a_ovf)
  );

  contador_mod_ud #(.WIDTH(4), .MODULO(10), .SATURA(1)) dut_b (
    .CLK(clk), .CLR(b_clr), .LD(b_ld), .ENP(b_enp), .ENT(b_ent), .UP(b_up),
    .D(b_d), .Q(b_q), .RCO(b_rco), .OVF(b_ovf)
  );

  contador_mod_ud #(.WIDTH(4), .MODULO(16), .SATURA(0)) dut_lo (
    .CLK(clk), .CLR(c_clr), .LD(1'b1), .ENP(c_en), .ENT(c_en), .UP(1'b1),
    .D(4'd0), .Q(lo_q), .RCO(lo_rco), .OVF(lo_ovf)
  );

  contador_mod_ud #(.WIDTH(4), .MODULO(16), .SATURA(0)) dut_hi (
    .CLK(clk), .CLR(c_clr), .LD(1'b1), .ENP(c_en), .ENT(lo_rco), .UP(1'b1),
    .D(4'd0), .Q(hi_q), .RCO(hi_rco), .OVF(hi_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_b [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_b   = '{4'd1, 4'd0, 4'd0, 4'd0};
    a_clr = 1; a_ld = 1; a_enp = 0; a_ent = 0; a_up = 1; a_d = 0;
    b_clr = 1; b_ld = 1; b_enp = 0; b_ent = 0; b_up = 1; b_d = 0;
    c_clr = 1; c_en = 0;

    // reset state
    step();
    chk("rst_q", 16'(a_q), 16'd0);
    chk("rst_ovf", 16'(a_ovf), 16'd0);
    chk("rst_rco_ent0", 16'(a_rco), 16'd0);
    a_ent = 1; a_up = 0; #1;
    chk("rst_rco_down", 16'(a_rco), 16'd1);

    // up count and wrap, modulo 10
    a_clr = 0; a_enp = 1; a_up = 1; #1;
    for (int i = 0; i < 12; i++) begin
      chk("up_rco", 16'(a_rco), (i % 10 == 9) ? 16'd1 : 16'd0);
      step();
      chk("up_q", 16'(a_q), 16'((i + 1) % 10));
      chk("up_ovf", 16'(a_ovf), (i == 9) ? 16'd1 : 16'd0);
    end

    // load clamp and priority
    a_enp = 0; a_d = 13; a_ld = 0;
    step();
    chk("ld_clamp", 16'(a_q), 16'd9);
    a_d = 5; a_clr = 1;
    step();
    chk("clr_over_ld", 16'(a_q), 16'd0);
    a_clr = 0; a_enp = 1; a_ent = 1;
    step();
    chk("ld_over_step", 16'(a_q), 16'd5);

    // enable gating
    a_d = 9;
    step();
    a_ld = 1; a_enp = 0;
    step();
    chk("enp0_hold", 16'(a_q), 16'd9);
    chk("enp0_rco", 16'(a_rco), 16'd1);
    a_ent = 0; #1;
    chk("ent0_rco", 16'(a_rco), 16'd0);
    a_ent = 1; a_up = 0; #1;
    chk("rco_follows_up", 16'(a_rco), 16'd0);

    // direction change takes effect on the next step
    a_enp = 1;
    step();
    chk("down_step", 16'(a_q), 16'd8);
    a_up = 1;
    step();
    chk("up_again", 16'(a_q), 16'd9);

    // load and reset on a would-be wrap edge suppress OVF
    a_ld = 0; a_d = 9;
    step();
    chk("ld_wrap_q", 16'(a_q), 16'd9);
    chk("ld_wrap_ovf", 16'(a_ovf), 16'd0);
    a_ld = 1; a_clr = 1;
    step();
    chk("clr_wrap_q", 16'(a_q), 16'd0);
    chk("clr_wrap_ovf", 16'(a_ovf), 16'd0);

    // down wrap at zero
    a_clr = 0; a_up = 0;
    step();
    chk("down_wrap_q", 16'(a_q), 16'd9);
    chk("down_wrap_ovf", 16'(a_ovf), 16'd1);
    a_enp = 0;
    step();
    chk("ovf_one_cycle", 16'(a_ovf), 16'd0);

    // saturating instance, counting down
    b_clr = 0; b_ld = 0; b_d = 2;
    step();
    chk("sat_ld", 16'(b_q), 16'd2);
    b_ld = 1; b_up = 0; b_enp = 1; b_ent = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_dn_q", 16'(b_q), 16'(exp_b[i]));
      chk("sat_dn_rco", 16'(b_rco), (exp_b[i] == 4'd0) ? 16'd1 : 16'd0);
      chk("sat_dn_ovf", 16'(b_ovf), 16'd0);
    end
    b_up = 1; b_ld = 0; b_d = 9;
    step();
    b_ld = 1;
    step();
    chk("sat_up_q", 16'(b_q), 16'd9);
    chk("sat_up_ovf", 16'(b_ovf), 16'd0);

    // two-stage cascade; 8 bits total, so 300 steps leave 300 mod 256 = 0x2C
    c_clr = 0; c_en = 1;
    repeat (15) step();
    chk("casc_lo15", 16'(lo_q), 16'd15);
    chk("casc_hi15", 16'(hi_q), 16'd0);
    step();
    chk("casc_lo16", 16'(lo_q), 16'd0);
    chk("casc_hi16", 16'(hi_q), 16'd1);
    repeat (284) step();
    chk("casc_300", 16'({hi_q, lo_q}), 16'h002C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
